// File: rtl/cpx_mult_arbiter_if.sv
// Bundle of requester, multiplier and result signals around the complex-multiplier arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface cpx_mult_arbiter_if #(
    parameter int x_bits    = 12,
    parameter int y_bits    = 12,
    parameter int out_bits  = 24,
    parameter int tag_depth = 8
);
    localparam int cnt_w = $clog2(tag_depth) + 1;

    logic                       req0_valid;
    logic                       req0_ready;
    logic signed [x_bits-1:0]   req0_xi;
    logic signed [x_bits-1:0]   req0_xq;
    logic signed [y_bits-1:0]   req0_yi;
    logic signed [y_bits-1:0]   req0_yq;

    logic                       req1_valid;
    logic                       req1_ready;
    logic signed [x_bits-1:0]   req1_xi;
    logic signed [x_bits-1:0]   req1_xq;
    logic signed [y_bits-1:0]   req1_yi;
    logic signed [y_bits-1:0]   req1_yq;

    logic                       mul_valid;
    logic                       mul_ready;
    logic signed [x_bits-1:0]   mul_xi;
    logic signed [x_bits-1:0]   mul_xq;
    logic signed [y_bits-1:0]   mul_yi;
    logic signed [y_bits-1:0]   mul_yq;
    logic                       mul_res_valid;
    logic signed [out_bits-1:0] mul_i;
    logic signed [out_bits-1:0] mul_q;

    logic                       res_valid;
    logic                       res_tag;
    logic signed [out_bits-1:0] res_i;
    logic signed [out_bits-1:0] res_q;
    logic [cnt_w-1:0]           inflight;
    logic                       err;

    modport slave (
        input  req0_valid, req0_xi, req0_xq, req0_yi, req0_yq,
        input  req1_valid, req1_xi, req1_xq, req1_yi, req1_yq,
        input  mul_ready, mul_res_valid, mul_i, mul_q,
        output req0_ready, req1_ready,
        output mul_valid, mul_xi, mul_xq, mul_yi, mul_yq,
        output res_valid, res_tag, res_i, res_q, inflight, err
    );

    modport master (
        output req0_valid, req0_xi, req0_xq, req0_yi, req0_yq,
        output req1_valid, req1_xi, req1_xq, req1_yi, req1_yq,
        output mul_ready, mul_res_valid, mul_i, mul_q,
        input  req0_ready, req1_ready,
        input  mul_valid, mul_xi, mul_xq, mul_yi, mul_yq,
        input  res_valid, res_tag, res_i, res_q, inflight, err
    );
endinterface

// File: rtl/cpx_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between two requesters; a tag FIFO
// remembers the owner of each issued product so in-order results are routed back.
module cpx_mult_arbiter #(
    parameter int x_bits    = 12,
    parameter int y_bits    = 12,
    parameter int out_bits  = 24,
    parameter int tag_depth = 8
) (
    input  logic               clk,
    input  logic               rst,
    cpx_mult_arbiter_if.slave  bus
);
    localparam int ptr_w = $clog2(tag_depth);
    localparam int cnt_w = ptr_w + 1;

    logic                       mul_valid_reg;
    logic signed [x_bits-1:0]   xi_reg, xq_reg;
    logic signed [y_bits-1:0]   yi_reg, yq_reg;
    logic                       slot_tag_reg;
    logic                       last_grant_reg;

    logic                       tag_mem [tag_depth];
    logic [ptr_w-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [cnt_w-1:0]           count_reg;
    logic [cnt_w-1:0]           count_next;

    logic                       res_valid_reg, res_tag_reg, err_reg;
    logic signed [out_bits-1:0] res_i_reg, res_q_reg;

    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic                       fire, pop, can_load, load, grant_idx;
    logic signed [x_bits-1:0]   sel_xi, sel_xq;
    logic signed [y_bits-1:0]   sel_yi, sel_yq;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign fire       = mul_valid_reg & bus.mul_ready;
    assign pop        = bus.mul_res_valid & (count_reg != '0);
    assign count_next = count_reg + cnt_w'(fire) - cnt_w'(pop);

    // The slot may refill in the same cycle it drains, but only if the FIFO keeps room
    // for the new product once it is eventually accepted.
    assign can_load  = ~rst & (~mul_valid_reg | fire) & (count_next < cnt_w'(tag_depth));
    assign grant_idx = (&req_valid) ? ~last_grant_reg : req_valid[1];
    assign load      = can_load & (|req_valid);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = load & (grant_idx == 1'(gi));
        end
    endgenerate

    assign sel_xi = grant_idx ? bus.req1_xi : bus.req0_xi;
    assign sel_xq = grant_idx ? bus.req1_xq : bus.req0_xq;
    assign sel_yi = grant_idx ? bus.req1_yi : bus.req0_yi;
    assign sel_yq = grant_idx ? bus.req1_yq : bus.req0_yq;

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr_reg] <= slot_tag_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_valid_reg  <= 1'b0;
            xi_reg         <= '0;
            xq_reg         <= '0;
            yi_reg         <= '0;
            yq_reg         <= '0;
            slot_tag_reg   <= 1'b0;
            last_grant_reg <= 1'b1;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_tag_reg    <= 1'b0;
            res_i_reg      <= '0;
            res_q_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (load) begin
                mul_valid_reg  <= 1'b1;
                xi_reg         <= sel_xi;
                xq_reg         <= sel_xq;
                yi_reg         <= sel_yi;
                yq_reg         <= sel_yq;
                slot_tag_reg   <= grant_idx;
                last_grant_reg <= grant_idx;
            end else if (fire) begin
                mul_valid_reg  <= 1'b0;
            end

            if (fire) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + ptr_w'(1);
                res_tag_reg <= tag_mem[rd_ptr_reg];
                res_i_reg   <= bus.mul_i;
                res_q_reg   <= bus.mul_q;
            end
            count_reg     <= count_next;
            res_valid_reg <= pop;

            // A result with nothing outstanding is unattributable; flag it and drop it.
            if (bus.mul_res_valid && count_reg == '0) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.mul_valid  = mul_valid_reg;
    assign bus.mul_xi     = xi_reg;
    assign bus.mul_xq     = xq_reg;
    assign bus.mul_yi     = yi_reg;
    assign bus.mul_yq     = yq_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_tag    = res_tag_reg;
    assign bus.res_i      = res_i_reg;
    assign bus.res_q      = res_q_reg;
    assign bus.inflight   = count_reg + cnt_w'(mul_valid_reg);
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_cpx_mult_arbiter.sv
// Bench for cpx_mult_arbiter: queue-based reference model compared every cycle, a simple
// multiplier stand-in computing products from the DUT's issued operands, and directed scenarios.
module tb_cpx_mult_arbiter;
    localparam int XB = 12;
    localparam int YB = 12;
    localparam int OB = 24;
    localparam int DEPTH = 8;

    typedef struct {
        bit                     tag;
        logic signed [OB-1:0]   pi;
        logic signed [OB-1:0]   pq;
    } ent_t;

    typedef struct {
        logic signed [OB-1:0] i;
        logic signed [OB-1:0] q;
    } prod_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpx_mult_arbiter_if #(.x_bits(XB), .y_bits(YB), .out_bits(OB), .tag_depth(DEPTH)) bus ();

    cpx_mult_arbiter #(.x_bits(XB), .y_bits(YB), .out_bits(OB), .tag_depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // reference model state
    bit                   m_slot = 1'b0;
    bit                   m_slot_tag = 1'b0;
    logic signed [XB-1:0] m_xi, m_xq;
    logic signed [YB-1:0] m_yi, m_yq;
    ent_t                 m_q[$];
    bit                   m_last = 1'b1;
    bit                   m_err = 1'b0;
    bit                   m_rv = 1'b0;
    bit                   m_rtag = 1'b0;
    logic signed [OB-1:0] m_ri, m_rq;

    prod_t                mq[$];
    int                   grants[$];
    int                   res_tags[$];
    logic                 last_rtag;
    logic signed [OB-1:0] last_ri, last_rq;

    bit                   fix_ops = 1'b0;
    logic signed [XB-1:0] f_xi, f_xq;
    logic signed [YB-1:0] f_yi, f_yq;

    function automatic prod_t cmul(input logic signed [XB-1:0] xi, input logic signed [XB-1:0] xq,
                                   input logic signed [YB-1:0] yi, input logic signed [YB-1:0] yq);
        prod_t  p;
        longint vi, vq;
        vi  = longint'(xi) * longint'(yi) - longint'(xq) * longint'(yq);
        vq  = longint'(xi) * longint'(yq) + longint'(xq) * longint'(yi);
        p.i = vi[OB-1:0];
        p.q = vq[OB-1:0];
        return p;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare and advance the model at negedge.
    // rv: 0 = no result, 1 = return next product if any, 2 = force a result pulse.
    task automatic cycle(input bit r, input bit v0, input bit v1, input bit mr, input int rv);
        bit    fire, pop, any, g, ld;
        int    cnt_after;
        ent_t  e;
        prod_t p;
        @(posedge clk);
        #1;
        rst            = r;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_xi    = fix_ops ? f_xi : XB'($urandom);
        bus.req0_xq    = fix_ops ? f_xq : XB'($urandom);
        bus.req0_yi    = fix_ops ? f_yi : YB'($urandom);
        bus.req0_yq    = fix_ops ? f_yq : YB'($urandom);
        bus.req1_xi    = XB'($urandom);
        bus.req1_xq    = XB'($urandom);
        bus.req1_yi    = YB'($urandom);
        bus.req1_yq    = YB'($urandom);
        bus.mul_ready  = mr;
        if (rv == 1 && mq.size() > 0) begin
            bus.mul_res_valid = 1'b1;
            bus.mul_i         = mq[0].i;
            bus.mul_q         = mq[0].q;
        end else begin
            bus.mul_res_valid = (rv == 2);
            bus.mul_i         = OB'($urandom);
            bus.mul_q         = OB'($urandom);
        end
        @(negedge clk);

        any       = v0 | v1;
        g         = (v0 & v1) ? !m_last : v1;
        fire      = m_slot & mr;
        pop       = bus.mul_res_valid && (m_q.size() != 0);
        cnt_after = m_q.size() + int'(fire) - int'(pop);
        ld        = !r && (!m_slot || fire) && (cnt_after < DEPTH) && any;

        if (checking) begin
            chk("req0_ready", bus.req0_ready, ld & !g);
            chk("req1_ready", bus.req1_ready, ld & g);
            chk("mul_valid", bus.mul_valid, m_slot);
            if (m_slot) begin
                chk("mul_xi", bus.mul_xi, m_xi);
                chk("mul_xq", bus.mul_xq, m_xq);
                chk("mul_yi", bus.mul_yi, m_yi);
                chk("mul_yq", bus.mul_yq, m_yq);
            end
            chk("res_valid", bus.res_valid, m_rv);
            if (m_rv) begin
                chk("res_tag", bus.res_tag, m_rtag);
                chk("res_i", bus.res_i, m_ri);
                chk("res_q", bus.res_q, m_rq);
            end
            chk("inflight", bus.inflight, m_q.size() + int'(m_slot));
            chk("err", bus.err, m_err);
        end

        if (bus.req0_valid && bus.req0_ready) grants.push_back(0);
        if (bus.req1_valid && bus.req1_ready) grants.push_back(1);
        if (bus.res_valid) begin
            res_tags.push_back(int'(bus.res_tag));
            last_rtag = bus.res_tag;
            last_ri   = bus.res_i;
            last_rq   = bus.res_q;
        end

        // multiplier stand-in sees exactly what the DUT hands it
        if (r) begin
            mq.delete();
        end else begin
            if (bus.mul_res_valid && mq.size() > 0) void'(mq.pop_front());
            if (bus.mul_valid && bus.mul_ready)
                mq.push_back(cmul(bus.mul_xi, bus.mul_xq, bus.mul_yi, bus.mul_yq));
        end

        if (r) begin
            m_slot = 1'b0; m_q.delete(); m_last = 1'b1; m_err = 1'b0; m_rv = 1'b0;
        end else begin
            m_rv = pop;
            if (pop) begin
                e      = m_q.pop_front();
                m_rtag = e.tag;
                m_ri   = e.pi;
                m_rq   = e.pq;
            end
            if (bus.mul_res_valid && !pop) m_err = 1'b1;
            if (fire) begin
                p    = cmul(m_xi, m_xq, m_yi, m_yq);
                e.tag = m_slot_tag; e.pi = p.i; e.pq = p.q;
                m_q.push_back(e);
            end
            if (ld) begin
                m_slot = 1'b1; m_slot_tag = g; m_last = g;
                m_xi = g ? bus.req1_xi : bus.req0_xi;
                m_xq = g ? bus.req1_xq : bus.req0_xq;
                m_yi = g ? bus.req1_yi : bus.req0_yi;
                m_yq = g ? bus.req1_yq : bus.req0_yq;
            end else if (fire) begin
                m_slot = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (m_q.size() > 0 || m_slot || m_rv); k++) cycle(0, 0, 0, 1, 1);
        chk("drain_inflight", bus.inflight, 0);
    endtask

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0; bus.mul_ready = 0; bus.mul_res_valid = 0;
        bus.req0_xi = 0; bus.req0_xq = 0; bus.req0_yi = 0; bus.req0_yq = 0;
        bus.req1_xi = 0; bus.req1_xq = 0; bus.req1_yi = 0; bus.req1_yq = 0;
        bus.mul_i = 0; bus.mul_q = 0;

        // reset values
        cycle(1, 0, 0, 0, 0);
        checking = 1'b1;
        cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_mul_valid", bus.mul_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_tag", bus.res_tag, 0);
        chk("rst_res_i", bus.res_i, 0);
        chk("rst_res_q", bus.res_q, 0);

        // (3+4j)(1-2j) = 11-2j from requester 0
        fix_ops = 1'b1; f_xi = 3; f_xq = 4; f_yi = 1; f_yq = -2;
        cycle(0, 1, 0, 1, 0);
        fix_ops = 1'b0;
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        chk("cm_res_valid", bus.res_valid, 1);
        chk("cm_tag", last_rtag, 0);
        chk("cm_i", last_ri, 11);
        chk("cm_q", last_rq, -2);

        // alternation with both requesters always valid
        cycle(1, 0, 0, 0, 0);
        grants.delete(); res_tags.delete();
        for (int k = 0; k < 8; k++) cycle(0, 1, 1, 1, 1);
        drain();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt_grant%0d", k), grants.size() > k ? grants[k] : -1, k % 2);
            chk($sformatf("alt_rtag%0d", k), res_tags.size() > k ? res_tags[k] : -1, k % 2);
        end

        // only requester 1
        grants.delete();
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 1);
        chk("r1_only_count", grants.size(), 4);
        chk("r1_only_sum", grants.sum(), 4);
        drain();

        // fill to tag_depth with no results returning
        cycle(1, 0, 0, 0, 0);
        grants.delete();
        for (int k = 0; k < 12; k++) cycle(0, 1, 1, 1, 0);
        chk("full_grants", grants.size(), 8);
        chk("full_inflight", bus.inflight, 8);
        cycle(0, 1, 1, 1, 1);
        chk("full_regrant", grants.size(), 9);
        for (int k = 0; k < 3; k++) cycle(0, 1, 1, 1, 0);
        chk("full_hold_grants", grants.size(), 9);
        chk("full_hold_inflight", bus.inflight, 8);
        drain();

        // stray result with nothing outstanding
        cycle(0, 0, 0, 1, 2);
        cycle(0, 0, 0, 1, 0);
        chk("stray_err", bus.err, 1);
        chk("stray_res_valid", bus.res_valid, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        chk("stray_err_sticky", bus.err, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("stray_err_cleared", bus.err, 0);

        // reset with three in flight
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        chk("mid_inflight3", bus.inflight, 3);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("mid_rst_inflight", bus.inflight, 0);
        chk("mid_rst_mul_valid", bus.mul_valid, 0);
        chk("mid_rst_err", bus.err, 0);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            cycle($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
